// File: rtl/cla_pipe_adder_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cla_pipe_adder_if                                          |
// | Description : Operand/result valid-ready stream bundle for the           |
// |               pipelined carry-lookahead adder/subtractor.                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface cla_pipe_adder_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic             zero;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf, zero
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf, zero
   );
endinterface
`default_nettype wire

// File: rtl/cla_pipe_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cla_pipe_adder                                             |
// | Description : Pipelined carry-lookahead adder/subtractor, one lookahead  |
// |               block of BLK bits per stage; optional signed saturation    |
// |               enabled by defining CLA_SAT_EN.                            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module cla_pipe_adder #(
   parameter int WIDTH = 16,
   parameter int BLK   = 4
) (
   input  wire logic          clk,
   input  wire logic          rst,
   cla_pipe_adder_if.slave    bus
);

   localparam int c_NBLK = WIDTH / BLK;

   if (WIDTH % BLK != 0) begin : g_bad_width
      $error("cla_pipe_adder: WIDTH must be a multiple of BLK");
   end
   if (BLK < 1 || BLK > 8) begin : g_bad_blk
      $error("cla_pipe_adder: BLK must be in 1..8");
   end

   // Flattened sum-of-products carries: c[i+1] depends only on p/g/ci.
   function automatic logic [BLK:0] blk_carries(
      input logic [BLK-1:0] p,
      input logic [BLK-1:0] g,
      input logic           ci
   );
      logic [BLK:0] c;
      logic         acc;
      logic         term;
      c    = '0;
      c[0] = ci;
      for (int i = 0; i < BLK; i++) begin
         acc = ci;
         for (int m = 0; m <= i; m++) acc = acc & p[m];
         for (int j = 0; j <= i; j++) begin
            term = g[j];
            for (int m = j + 1; m <= i; m++) term = term & p[m];
            acc = acc | term;
         end
         c[i+1] = acc;
      end
      return c;
   endfunction

   // Rank k holds the operands entering lookahead block k.
   logic             r_v [0:c_NBLK-1];
   logic [WIDTH-1:0] r_a [0:c_NBLK-1];
   logic [WIDTH-1:0] r_b [0:c_NBLK-1];
   logic [WIDTH-1:0] r_s [0:c_NBLK-1];
   logic             r_c [0:c_NBLK-1];

   logic             r_out_v;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_ovf;
   logic             r_zero;

   logic [WIDTH-1:0] w_s [0:c_NBLK-1];
   logic             w_c [0:c_NBLK-1];
   logic             w_cmsb [0:c_NBLK-1];
   logic             w_stall;
   logic             w_ovf;
   logic [WIDTH-1:0] w_sum_fin;

   for (genvar k = 0; k < c_NBLK; k++) begin : g_stage
      logic [BLK-1:0] w_p;
      logic [BLK-1:0] w_g;
      logic [BLK:0]   w_cv;
      logic [WIDTH-1:0] w_snew;

      assign w_p  = r_a[k][k*BLK +: BLK] ^ r_b[k][k*BLK +: BLK];
      assign w_g  = r_a[k][k*BLK +: BLK] & r_b[k][k*BLK +: BLK];
      assign w_cv = blk_carries(w_p, w_g, r_c[k]);

      always_comb begin
         w_snew                 = r_s[k];
         w_snew[k*BLK +: BLK]   = w_p ^ w_cv[BLK-1:0];
      end

      assign w_s[k]    = w_snew;
      assign w_c[k]    = w_cv[BLK];
      assign w_cmsb[k] = w_cv[BLK-1];
   end

   assign w_stall = r_out_v & ~bus.out_ready;
   assign w_ovf   = w_cmsb[c_NBLK-1] ^ w_c[c_NBLK-1];

`ifdef CLA_SAT_EN
   // Overflow only occurs with like-signed operands, so A's sign picks the rail.
   assign w_sum_fin = !w_ovf ? w_s[c_NBLK-1] :
                      r_a[c_NBLK-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} :
                                               {1'b0, {(WIDTH-1){1'b1}}};
`else
   assign w_sum_fin = w_s[c_NBLK-1];
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < c_NBLK; k++) begin
            r_v[k] <= 1'b0;
            r_a[k] <= '0;
            r_b[k] <= '0;
            r_s[k] <= '0;
            r_c[k] <= 1'b0;
         end
         r_out_v <= 1'b0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
         r_zero  <= 1'b0;
      end else if (!w_stall) begin
         r_v[0] <= bus.in_valid;
         r_a[0] <= bus.a;
         r_b[0] <= bus.sub ? ~bus.b : bus.b;
         r_c[0] <= bus.sub | bus.cin;
         r_s[0] <= '0;
         for (int k = 1; k < c_NBLK; k++) begin
            r_v[k] <= r_v[k-1];
            r_a[k] <= r_a[k-1];
            r_b[k] <= r_b[k-1];
            r_s[k] <= w_s[k-1];
            r_c[k] <= w_c[k-1];
         end
         r_out_v <= r_v[c_NBLK-1];
         r_sum   <= w_sum_fin;
         r_cout  <= w_c[c_NBLK-1];
         r_ovf   <= w_ovf;
         r_zero  <= ~|w_sum_fin;
      end
   end

   assign bus.in_ready  = ~w_stall;
   assign bus.out_valid = r_out_v;
   assign bus.sum       = r_sum;
   assign bus.cout      = r_cout;
   assign bus.ovf       = r_ovf;
   assign bus.zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_cla_pipe_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_cla_pipe_adder                                          |
// | Description : Scoreboard bench for cla_pipe_adder (WIDTH=16, BLK=4).     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_cla_pipe_adder;

   localparam int c_W    = 16;
   localparam int c_NBLK = 4;

   typedef struct {
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
      logic        zero;
      int          acc;
      bit          chk_lat;
   } exp_t;

   logic clk;
   logic rst;
   cla_pipe_adder_if #(.WIDTH(c_W)) bus ();

   cla_pipe_adder #(.WIDTH(c_W), .BLK(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int    total = 0;
   int    bad   = 0;
   int    cyc   = 0;
   exp_t  sb [$];
   exp_t  mon_e;
   bit    lat_mode   = 0;
   bit    seen       = 0;
   int    seen_cyc   = 0;
   bit    prev_stall = 0;
   logic [31:0] prev_out;
   bit    rand_done;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h required %h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   // Reference: integer arithmetic on the operands' unsigned and signed values.
   function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                  input logic cin, input logic sub);
      exp_t   e;
      longint ua, ub, sa, sbv, ci, ru, rs;
      ua  = a;
      ub  = b;
      sa  = $signed(a);
      sbv = $signed(b);
      ci  = cin;
      if (sub) begin
         ru     = ua - ub;
         rs     = sa - sbv;
         e.cout = (ua >= ub);
      end else begin
         ru     = ua + ub + ci;
         rs     = sa + sbv + ci;
         e.cout = (ru > 65535);
      end
      e.ovf = (rs > 32767) || (rs < -32768);
      e.sum = ru[15:0];
`ifdef CLA_SAT_EN
      if (e.ovf) e.sum = (rs > 0) ? 16'h7FFF : 16'h8000;
`endif
      e.zero    = (e.sum == 16'h0000);
      e.acc     = 0;
      e.chk_lat = 0;
      return e;
   endfunction

   // Monitor: handshakes seen at the falling edge complete at the next rising edge.
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
         seen       = 0;
         prev_stall = 0;
      end else begin
         check("in_ready", {31'd0, bus.in_ready}, {31'd0, !(bus.out_valid && !bus.out_ready)});
         if (prev_stall)
            check("hold", {13'd0, bus.sum, bus.cout, bus.ovf, bus.zero}, prev_out);
         if (bus.in_valid && bus.in_ready) begin
            mon_e         = model(bus.a, bus.b, bus.cin, bus.sub);
            mon_e.acc     = cyc + 1;
            mon_e.chk_lat = lat_mode;
            sb.push_back(mon_e);
         end
         if (bus.out_valid && !seen) begin
            seen     = 1;
            seen_cyc = cyc;
         end
         if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_output: got sum=%h with nothing outstanding", bus.sum);
            end else begin
               mon_e = sb.pop_front();
               check("sum",  {16'd0, bus.sum},  {16'd0, mon_e.sum});
               check("cout", {31'd0, bus.cout}, {31'd0, mon_e.cout});
               check("ovf",  {31'd0, bus.ovf},  {31'd0, mon_e.ovf});
               check("zero", {31'd0, bus.zero}, {31'd0, mon_e.zero});
               if (mon_e.chk_lat)
                  check("latency", seen_cyc - mon_e.acc, c_NBLK);
            end
            seen = 0;
         end
         prev_stall = bus.out_valid && !bus.out_ready;
         prev_out   = {13'd0, bus.sum, bus.cout, bus.ovf, bus.zero};
      end
   end

   task automatic send(input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic sub);
      int n = 0;
      bus.in_valid = 1'b1;
      bus.a        = a;
      bus.b        = b;
      bus.cin      = cin;
      bus.sub      = sub;
      @(negedge clk);
      while (!bus.in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         total++;
         bad++;
         $display("FAIL send_timeout: in_ready stuck at %b, required 1", bus.in_ready);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic send_rand();
      logic [15:0] a, b;
      a = 16'($urandom);
      b = 16'($urandom);
      case ($urandom_range(0, 5))
         0: a = 16'h7FFF;
         1: b = 16'hFFFF;
         2: b = a;
         default: ;
      endcase
      send(a, b, 1'($urandom), 1'($urandom));
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(posedge clk);
         n++;
      end
      repeat (2) @(posedge clk);
      #1;
      check("drain", sb.size(), 0);
   endtask

   initial begin
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.cin       = 1'b0;
      bus.sub       = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", {31'd0, bus.out_valid}, 0);
      check("rst_outputs", {13'd0, bus.sum, bus.cout, bus.ovf, bus.zero}, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", {31'd0, bus.in_ready}, 1);

      // Directed corner cases with latency tracking.
      @(posedge clk);
      #1 lat_mode = 1;
      send(16'h00FF, 16'h0001, 1'b0, 1'b0);
      send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
      send(16'h0005, 16'h0007, 1'b1, 1'b1);
      send(16'h0007, 16'h0005, 1'b0, 1'b1);
      send(16'h8000, 16'h0001, 1'b0, 1'b1);
      send(16'h8000, 16'h8000, 1'b1, 1'b0);
      wait_drain();
      lat_mode = 0;

      // Six back-to-back beats with a three-cycle output stall.
      fork
         begin
            for (int i = 0; i < 6; i++) send_rand();
         end
         begin
            repeat (5) @(posedge clk);
            #1 bus.out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1 bus.out_ready = 1'b1;
         end
      join
      wait_drain();

      // Two beats in flight, then reset: both must vanish.
      send(16'h1234, 16'h1111, 1'b0, 1'b0);
      send(16'h4321, 16'h0001, 1'b1, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("midrst_out_valid", {31'd0, bus.out_valid}, 0);
      check("midrst_outputs", {13'd0, bus.sum, bus.cout, bus.ovf, bus.zero}, 0);
      check("midrst_in_ready", {31'd0, bus.in_ready}, 1);
      @(posedge clk);
      #1 lat_mode = 1;
      send(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
      wait_drain();
      lat_mode = 0;

      // Random stream with random gaps and random backpressure.
      rand_done = 0;
      fork
         begin
            for (int i = 0; i < 60; i++) begin
               send_rand();
               if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
               #1;
            end
            rand_done = 1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk);
               #1 bus.out_ready = ($urandom_range(0, 3) != 0);
            end
            bus.out_ready = 1'b1;
         end
      join
      wait_drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
